// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery-form conversion path: FSM encoding and
// the modulus legality rule also used by mod_exponent's driver.
package mont_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } mont_conv_state_t;

  // Odd and >= 3: given an odd value, it is >= 3 unless it is exactly 1.
  function automatic logic is_legal_modulus(input logic [1:0] low_bits,
                                            input logic       upper_nonzero);
    return low_bits[0] && (low_bits[1] || upper_nonzero);
  endfunction

endpackage

// File: rtl/mod_double_step.sv
// One modular doubling step: doubled = 2*acc mod modulus, assuming acc < modulus.
module mod_double_step #(
  parameter int WIDTH = 512
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] doubled
);

  logic [WIDTH:0] t;
  logic [WIDTH:0] n_ext;

  assign t     = {acc, 1'b0};
  assign n_ext = {1'b0, modulus};

  // The true result is below modulus, so WIDTH-bit wraparound subtraction is exact.
  assign doubled = (t >= n_ext) ? (t[WIDTH-1:0] - modulus) : t[WIDTH-1:0];

endmodule

// File: rtl/mont_converter.sv
// Converts a plain operand into Montgomery form: base*2^WIDTH mod N and 2^WIDTH mod N,
// by WIDTH parallel modular doublings of the two accumulators.
module mont_converter
  import mont_pkg::*;
#(
  parameter int WIDTH = 512
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] modulo,
  input  logic             valid_in,
  output logic [WIDTH-1:0] base_mont,
  output logic [WIDTH-1:0] one_mont,
  output logic             valid_out,
  output logic             error_out,
  output logic             busy_out,
  output mont_conv_state_t state
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  mont_conv_state_t state_next;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] acc_b;
  logic [WIDTH-1:0] acc_1;
  logic [WIDTH-1:0] n_reg;
  logic [WIDTH-1:0] dbl_b;
  logic [WIDTH-1:0] dbl_1;
  logic             err_flag;
  logic             legal;
  logic             accept;

  assign legal = is_legal_modulus(modulo[1:0], |modulo[WIDTH-1:2]) && (base < modulo);

  mod_double_step #(.WIDTH(WIDTH)) u_step_b (
    .acc     (acc_b),
    .modulus (n_reg),
    .doubled (dbl_b)
  );

  mod_double_step #(.WIDTH(WIDTH)) u_step_1 (
    .acc     (acc_1),
    .modulus (n_reg),
    .doubled (dbl_1)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  // A request coinciding with the result pulse is dropped; valid_out is high in IDLE.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (valid_in && !valid_out) begin
          accept     = 1'b1;
          state_next = legal ? SHIFT : DONE;
        end
      end
      SHIFT:   if (counter == LAST_STEP) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      counter   <= '0;
      acc_b     <= '0;
      acc_1     <= '0;
      n_reg     <= '0;
      err_flag  <= 1'b0;
      base_mont <= '0;
      one_mont  <= '0;
      valid_out <= 1'b0;
      error_out <= 1'b0;
      busy_out  <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            n_reg     <= modulo;
            busy_out  <= 1'b1;
            error_out <= 1'b0;
            err_flag  <= !legal;
            acc_b     <= base;
            acc_1     <= WIDTH'(1);
            counter   <= '0;
          end
        end
        SHIFT: begin
          acc_b   <= dbl_b;
          acc_1   <= dbl_1;
          counter <= counter + CW'(1);
        end
        DONE: begin
          base_mont <= err_flag ? '0 : acc_b;
          one_mont  <= err_flag ? '0 : acc_1;
          error_out <= err_flag;
          valid_out <= 1'b1;
          busy_out  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_converter.sv
// Bench for mont_converter: an 8-bit and a 16-bit instance checked every cycle
// against an arithmetic reference model of Montgomery-form conversion.
module tb_mont_converter;
  import mont_pkg::*;

  logic clk;
  logic rst;

  logic [7:0]  b8, n8, bm8, om8;
  logic        v8, vo8, e8, busy8;
  mont_conv_state_t st8;

  logic [15:0] b16, n16, bm16, om16;
  logic        v16, vo16, e16, busy16;
  mont_conv_state_t st16;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;
  bit run = 0;

  // Expected entries packed as {error, one_mont, base_mont}.
  logic [16:0] exp8_q[$];
  int          due8_q[$];
  logic [32:0] exp16_q[$];
  int          due16_q[$];

  logic [7:0]  last_bm8, last_om8;
  logic        last_e8;
  logic [15:0] last_bm16, last_om16;
  logic        last_e16;
  bit          ev8, ev16;

  mont_converter #(.WIDTH(8)) dut8 (
    .clk_in    (clk),
    .rst_in    (rst),
    .base      (b8),
    .modulo    (n8),
    .valid_in  (v8),
    .base_mont (bm8),
    .one_mont  (om8),
    .valid_out (vo8),
    .error_out (e8),
    .busy_out  (busy8),
    .state     (st8)
  );

  mont_converter #(.WIDTH(16)) dut16 (
    .clk_in    (clk),
    .rst_in    (rst),
    .base      (b16),
    .modulo    (n16),
    .valid_in  (v16),
    .base_mont (bm16),
    .one_mont  (om16),
    .valid_out (vo16),
    .error_out (e16),
    .busy_out  (busy16),
    .state     (st16)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic void model(input int w, input longint unsigned bb, input longint unsigned nn,
                                output logic err, output longint unsigned one,
                                output longint unsigned bm);
    err = (nn % 2 == 0) || (nn < 3) || (bb >= nn);
    one = err ? 0 : ((64'd1 << w) % nn);
    bm  = err ? 0 : ((bb << w) % nn);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- drivers ----------------
  task automatic job8(input logic [7:0] b, input logic [7:0] n, output int due);
    logic err;
    longint unsigned one, bm;
    @(negedge clk);
    b8 = b; n8 = n; v8 = 1'b1;
    @(posedge clk);
    #1;
    v8 = 1'b0;
    model(8, 64'(b), 64'(n), err, one, bm);
    due = cyc + (err ? 1 : 9);
    exp8_q.push_back({err, 8'(one), 8'(bm)});
    due8_q.push_back(due);
    last_e8 = 1'b0;
    b8 = 8'($urandom);
    n8 = 8'($urandom);
  endtask

  task automatic job16(input logic [15:0] b, input logic [15:0] n, output int due);
    logic err;
    longint unsigned one, bm;
    @(negedge clk);
    b16 = b; n16 = n; v16 = 1'b1;
    @(posedge clk);
    #1;
    v16 = 1'b0;
    model(16, 64'(b), 64'(n), err, one, bm);
    due = cyc + (err ? 1 : 17);
    exp16_q.push_back({err, 16'(one), 16'(bm)});
    due16_q.push_back(due);
    last_e16 = 1'b0;
    b16 = 16'($urandom);
    n16 = 16'($urandom);
  endtask

  task automatic wait_idle8();
    int t = 0;
    while (exp8_q.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("d8_job_timeout", 64'(exp8_q.size()), 64'd0);
    exp8_q.delete();
    due8_q.delete();
  endtask

  task automatic wait_idle16();
    int t = 0;
    while (exp16_q.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("d16_job_timeout", 64'(exp16_q.size()), 64'd0);
    exp16_q.delete();
    due16_q.delete();
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (run && !rst) begin
      ev8 = (due8_q.size() > 0) ? (cyc == due8_q[0]) : 1'b0;
      chk("d8_valid_out", 64'(vo8), 64'(ev8));
      chk("d8_busy_out", 64'(busy8), 64'((due8_q.size() > 0) ? (cyc < due8_q[0]) : 1'b0));
      if (ev8) begin
        {last_e8, last_om8, last_bm8} = exp8_q.pop_front();
        void'(due8_q.pop_front());
      end
      chk("d8_base_mont", 64'(bm8), 64'(last_bm8));
      chk("d8_one_mont", 64'(om8), 64'(last_om8));
      chk("d8_error_out", 64'(e8), 64'(last_e8));

      ev16 = (due16_q.size() > 0) ? (cyc == due16_q[0]) : 1'b0;
      chk("d16_valid_out", 64'(vo16), 64'(ev16));
      chk("d16_busy_out", 64'(busy16), 64'((due16_q.size() > 0) ? (cyc < due16_q[0]) : 1'b0));
      if (ev16) begin
        {last_e16, last_om16, last_bm16} = exp16_q.pop_front();
        void'(due16_q.pop_front());
      end
      chk("d16_base_mont", 64'(bm16), 64'(last_bm16));
      chk("d16_one_mont", 64'(om16), 64'(last_om16));
      chk("d16_error_out", 64'(e16), 64'(last_e16));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int d;
    logic [15:0] rn, rb;
    rst = 1'b1;
    v8 = 1'b0; b8 = '0; n8 = '0;
    v16 = 1'b0; b16 = '0; n16 = '0;
    last_bm8 = '0; last_om8 = '0; last_e8 = 1'b0;
    last_bm16 = '0; last_om16 = '0; last_e16 = 1'b0;
    #1;
    chk("rst_base_mont", 64'(bm8), 64'd0);
    chk("rst_one_mont", 64'(om8), 64'd0);
    chk("rst_valid_out", 64'(vo8), 64'd0);
    chk("rst_error_out", 64'(e8), 64'd0);
    chk("rst_busy_out", 64'(busy8), 64'd0);
    chk("rst_state", 64'(st8), 64'(IDLE));
    chk("rst_d16_busy", 64'(busy16), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run = 1;

    // basic job and Montgomery form of 1
    job8(8'd5, 8'd13, d);
    wait_idle8();
    chk("t1_base_mont", 64'(bm8), 64'd6);
    chk("t1_one_mont", 64'(om8), 64'd9);
    chk("t1_error_out", 64'(e8), 64'd0);

    // N = 255: 2^8 mod N = 1, doubling lands just above N
    job8(8'd7, 8'd255, d);
    wait_idle8();
    chk("t2_base_mont", 64'(bm8), 64'd7);
    chk("t2_one_mont", 64'(om8), 64'd1);
    job8(8'd254, 8'd255, d);
    wait_idle8();
    chk("t2b_base_mont", 64'(bm8), 64'd254);

    // illegal operands
    job8(8'd3, 8'd12, d);
    wait_idle8();
    chk("t3_even_err", 64'(e8), 64'd1);
    chk("t3_even_bm", 64'(bm8), 64'd0);
    job8(8'd13, 8'd13, d);
    wait_idle8();
    chk("t3_base_ge_err", 64'(e8), 64'd1);
    chk("t3_base_ge_om", 64'(om8), 64'd0);
    job8(8'd0, 8'd1, d);
    wait_idle8();
    chk("t3_mod1_err", 64'(e8), 64'd1);

    // requests while busy and during the result pulse are ignored
    job8(8'd5, 8'd13, d);
    repeat (3) @(negedge clk);
    b8 = 8'd1; n8 = 8'd11; v8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    for (int t = 0; t < 50 && cyc < d; t++) @(negedge clk);
    b8 = 8'd1; n8 = 8'd11; v8 = 1'b1;
    @(posedge clk);
    #1;
    v8 = 1'b0;
    wait_idle8();
    chk("t4_first_bm", 64'(bm8), 64'd6);
    chk("t4_first_om", 64'(om8), 64'd9);
    job8(8'd1, 8'd11, d);
    wait_idle8();
    chk("t4_second_bm", 64'(bm8), 64'd3);
    chk("t4_second_om", 64'(om8), 64'd3);

    // asynchronous reset mid-SHIFT aborts the job
    job8(8'd5, 8'd13, d);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t5_rst_bm", 64'(bm8), 64'd0);
    chk("t5_rst_om", 64'(om8), 64'd0);
    chk("t5_rst_busy", 64'(busy8), 64'd0);
    chk("t5_rst_valid", 64'(vo8), 64'd0);
    chk("t5_rst_state", 64'(st8), 64'(IDLE));
    exp8_q.delete(); due8_q.delete();
    last_bm8 = '0; last_om8 = '0; last_e8 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    job8(8'd5, 8'd13, d);
    wait_idle8();
    chk("t5_after_bm", 64'(bm8), 64'd6);
    chk("t5_after_om", 64'(om8), 64'd9);

    // random 8-bit operands, legal and illegal
    for (int i = 0; i < 40; i++) begin
      job8(8'($urandom), 8'($urandom), d);
      wait_idle8();
    end

    // 16-bit boundaries, then random legal operands
    job16(16'd65534, 16'd65535, d);
    wait_idle16();
    chk("t6_max_bm", 64'(bm16), 64'd65534);
    chk("t6_max_om", 64'(om16), 64'd1);
    job16(16'd2, 16'd3, d);
    wait_idle16();
    chk("t6_n3_bm", 64'(bm16), 64'd2);
    chk("t6_n3_om", 64'(om16), 64'd1);
    for (int i = 0; i < 200; i++) begin
      rn = 16'($urandom_range(1, 32767) * 2 + 1);
      rb = 16'($urandom_range(0, 32'(rn) - 1));
      job16(rb, rn, d);
      wait_idle16();
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
